pc_seq_ctrl: RTL and testbench
==============================

# pc_seq_ctrl

Program-counter sequencer for the single-cycle RV32 core. It owns the PC register and sequences instruction fetch through a req/ready handshake with instruction memory. It resolves the next PC from three sources, in priority order: trap vector, branch/jump target, PC+4. It drives `pc_src` to the datapath's next-PC mux and keeps a retired-instruction counter.

## Interface
Parameters:
- `RESET_VEC`, 32'h0000_0000, PC loaded on reset
- `TRAP_VEC`, 32'h0000_0100, PC loaded on trap or misaligned target

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `branch`  in  1  decoded branch instruction
- `zero`  in  1  ALU zero flag
- `jump`  in  1  decoded JAL/JALR
- `pc_target`  in  32  branch/jump target from datapath adder
- `stall`  in  1  hazard hold request
- `trap`  in  1  synchronous exception/interrupt request
- `imem_ready`  in  1  instruction memory returns data this cycle
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, equal to `pc`
- `pc`  out  32  current PC (registered)
- `pc_plus4`  out  32  `pc + 4`, combinational
- `pc_src`  out  1  `(branch & zero) | jump`, combinational
- `fetch_fire`  out  1  accept strobe: `imem_req & imem_ready`
- `instret`  out  32  count of accepted fetches
- `misalign_err`  out  1  misaligned redirect strobe (see Configuration)

## Operation
- FSM states: BOOT, FETCH, STALL.
- BOOT:
  - Entered on reset. `imem_req`=0.
  - Always moves to FETCH on the next edge.
- FETCH:
  - `imem_req` = `!stall`.
  - `stall`=1 and `trap`=0: go to STALL. PC holds.
  - Accept (`fetch_fire`=1): load PC with `TRAP_VEC` if `trap`, else `pc_target` if `pc_src`, else `pc_plus4`. `instret` increments.
  - `trap`=1 without accept: PC <= `TRAP_VEC`, `instret` holds, state stays FETCH. A pending request is abandoned.
- STALL:
  - `imem_req`=0.
  - `trap`=1: PC <= `TRAP_VEC` and go to FETCH; trap beats stall.
  - Else go to FETCH when `stall`=0; otherwise stay.
- `branch`, `zero`, `jump` and `pc_target` are sampled only on an accept cycle.
- `instret` wraps 32'hFFFF_FFFF -> 0.
- PC arithmetic is modulo 2^32: `pc_plus4` of 32'hFFFF_FFFC is 0.
- Reset mid-fetch: asynchronous. All state returns to reset values immediately; no partial update.

## Timing
- Reset values:
  - `pc`=`RESET_VEC`, state=BOOT, `instret`=0.
  - `imem_req`=0, `fetch_fire`=0, `misalign_err`=0.
  - `imem_addr`=`RESET_VEC`.
- First `imem_req` is asserted in the 2nd cycle after `rst_n` rises (one cycle in BOOT).
- New PC is visible the cycle after accept. Throughput is one instruction per cycle while `imem_ready`=1 and `stall`=0.
- `fetch_fire` and `misalign_err` are combinational, valid in the accept cycle only.
- Leaving STALL costs one cycle with `imem_req`=0 beyond the deassertion of `stall`.

## Configuration
- Macro: `PC_MISALIGN_TRAP_EN`.
- Defined: on accept with `trap`=0, `pc_src`=1 and `pc_target[1:0]`!=0:
  - PC <= `TRAP_VEC`.
  - `misalign_err`=1 that cycle.
  - `instret` still increments.
- Undefined:
  - `pc_target[1:0]` is forced to 2'b00 before loading.
  - `misalign_err` is tied to 0.

## Test plan
- Sequential fetch: reset release, `imem_ready`=1, no redirects. Required:
  - `imem_req` rises in cycle 2.
  - `pc` steps 0,4,8,12.
  - `instret`=3 after three accepts.
- Branch/jump: accept with `branch`=1, `zero`=1, `pc_target`=32'h40, so `pc`=32'h40 next cycle. Then accept with `branch`=1, `zero`=0: `pc`=32'h44. Then `jump`=1, `pc_target`=32'h200: `pc`=32'h200.
- Stall and wait:
  - `stall`=1 for 3 cycles: `imem_req`=0, `pc` frozen, `instret` unchanged.
  - `imem_ready`=0 for 2 cycles in FETCH: `imem_req`=1, `pc` held.
- Trap priority:
  - `trap`=1 together with `pc_src`=1 on accept: `pc`=32'h100.
  - `trap`=1 in STALL: `pc`=32'h100, state FETCH.
  - `trap`=1 while waiting on `imem_ready`: `pc`=32'h100, `instret` unchanged.
- Misaligned target: `pc_target`=32'h42, `jump`=1 on accept.
  - Macro defined: `pc`=32'h100, `misalign_err`=1.
  - Macro undefined: `pc`=32'h40, `misalign_err`=0.
- Wrap and reset:
  - Preload via fetch from 32'hFFFF_FFFC: next `pc`=0.
  - Assert `rst_n`=0 mid-accept: `pc`=`RESET_VEC` and `imem_req`=0 immediately.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: program-counter sequencer for the single-cycle RV32 core.
//
// Owns the PC register. Fetches instructions from instruction memory through a
// req/ready handshake. On each accepted fetch, the next PC is chosen in this
// priority order:
//   1. trap vector
//   2. branch/jump target
//   3. PC+4
// The block also counts retired (accepted) fetches.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a redirect to a target that is not word-aligned traps to
//               TRAP_VEC and pulses misalign_err.
//   undefined : target bits [1:0] are cleared, and misalign_err is tied to 0.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   branch, zero   decoded branch, ALU zero flag
//   jump           decoded JAL/JALR
//   pc_target      redirect target from the datapath adder
//   stall          hazard hold request
//   trap           synchronous exception/interrupt request
//   imem_ready     instruction memory accepts/returns this cycle
//   imem_req       fetch request
//   imem_addr      fetch address (= pc)
//   pc             current PC (registered)
//   pc_plus4       pc + 4 (combinational)
//   pc_src         redirect select for the datapath next-PC mux
//   fetch_fire     accept strobe
//   instret        accepted-fetch counter (wraps)
//   misalign_err   misaligned-redirect strobe
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [31:0] pc_target,
  input  logic        stall,
  input  logic        trap,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_src,
  output logic        fetch_fire,
  output logic [31:0] instret,
  output logic        misalign_err
);

  typedef enum logic [1:0] {StBoot, StFetch, StStall} state_e;

  state_e      state;
  logic [31:0] pc_next;
  logic [31:0] target_eff;
  logic        misalign;

  assign pc_plus4   = pc + 32'd4;
  assign pc_src     = (branch & zero) | jump;
  assign imem_req   = (state == StFetch) & ~stall;
  assign imem_addr  = pc;
  assign fetch_fire = imem_req & imem_ready;

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign     = pc_src & (pc_target[1:0] != 2'b00);
  assign target_eff   = pc_target;
  assign misalign_err = fetch_fire & ~trap & misalign;
`else
  assign misalign     = 1'b0;
  assign target_eff   = pc_target & ~32'd3;
  assign misalign_err = 1'b0;
`endif

  // Next PC on an accept: trap first, then redirect, then sequential.
  always_comb begin
    pc_next = pc_plus4;
    if (trap || (pc_src && misalign)) begin
      pc_next = TRAP_VEC;
    end else if (pc_src) begin
      pc_next = target_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StBoot;
      pc      <= RESET_VEC;
      instret <= 32'd0;
    end else begin
      unique case (state)
        StBoot: begin
          state <= StFetch;
        end
        StFetch: begin
          if (fetch_fire) begin
            pc      <= pc_next;
            instret <= instret + 32'd1;
          end else if (trap) begin
            // Abandon any outstanding request; do not count it as retired.
            pc <= TRAP_VEC;
          end else if (stall) begin
            state <= StStall;
          end
        end
        StStall: begin
          if (trap) begin
            pc    <= TRAP_VEC;
            state <= StFetch;
          end else if (!stall) begin
            state <= StFetch;
          end
        end
        default: begin
          state <= StBoot;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] pc_target;
  logic        stall;
  logic        trap;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic        fetch_fire;
  logic [31:0] instret;
  logic        misalign_err;

  pc_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch       (branch),
    .zero         (zero),
    .jump         (jump),
    .pc_target    (pc_target),
    .stall        (stall),
    .trap         (trap),
    .imem_ready   (imem_ready),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .pc_src       (pc_src),
    .fetch_fire   (fetch_fire),
    .instret      (instret),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        trap;
    logic        rdy;
    logic        br;
    logic        zr;
    logic        jmp;
    logic [31:0] tgt;
    logic        req;
    logic        fire;
    logic        mis;
    logic [31:0] pc;
    logic [31:0] ir;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  vec_t        vecs[25];
  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic t, input logic r, input logic b,
                              input logic z, input logic j, input logic [31:0] tg,
                              input logic q, input logic f, input logic m,
                              input logic [31:0] p, input logic [31:0] i);
    vec_t v;
    v.stall = s; v.trap = t; v.rdy = r; v.br = b; v.zr = z; v.jmp = j; v.tgt = tg;
    v.req = q; v.fire = f; v.mis = m; v.pc = p; v.ir = i;
    return v;
  endfunction

  // One cycle: drive at negedge, check combinational outputs, then check state after the edge.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    stall = v.stall; trap = v.trap; imem_ready = v.rdy;
    branch = v.br; zero = v.zr; jump = v.jmp; pc_target = v.tgt;
    sb.push_back('{pc: v.pc, ir: v.ir});
    #1;
    chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, v.req});
    chk({tag, " fetch_fire"}, {31'd0, fetch_fire}, {31'd0, v.fire});
    chk({tag, " misalign_err"}, {31'd0, misalign_err}, {31'd0, v.mis});
    chk({tag, " imem_addr"}, imem_addr, model_pc);
    chk({tag, " pc_plus4"}, pc_plus4, model_pc + 32'd4);
    chk({tag, " pc_src"}, {31'd0, pc_src}, {31'd0, (v.br & v.zr) | v.jmp});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " pc"}, pc, e.pc);
      chk({tag, " instret"}, instret, e.ir);
      model_pc = e.pc;
    end
  endtask

  initial begin
    logic        mis_exp;
    logic [31:0] mis_pc;
    logic [31:0] after_mis;
`ifdef PC_MISALIGN_TRAP_EN
    mis_exp = 1'b1; mis_pc = 32'h100; after_mis = 32'h104;
`else
    mis_exp = 1'b0; mis_pc = 32'h40; after_mis = 32'h44;
`endif
    after_mis = after_mis;
    //           st tr rd br zr jm target        rq fi mi  pc             ir
    vecs[0]  = mk(0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0);  // boot
    vecs[1]  = mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 1, 0, 32'h4,         1);
    vecs[2]  = mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 1, 0, 32'h8,         2);
    vecs[3]  = mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 1, 0, 32'hC,         3);
    vecs[4]  = mk(0, 0, 1, 1, 1, 0, 32'h40,       1, 1, 0, 32'h40,        4);  // taken
    vecs[5]  = mk(0, 0, 1, 1, 0, 0, 32'h80,       1, 1, 0, 32'h44,        5);  // not taken
    vecs[6]  = mk(0, 0, 1, 0, 0, 1, 32'h200,      1, 1, 0, 32'h200,       6);  // jump
    vecs[7]  = mk(1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h200,       6);  // -> stall
    vecs[8]  = mk(1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h200,       6);
    vecs[9]  = mk(1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h200,       6);
    vecs[10] = mk(0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h200,       6);  // exit bubble
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h200,       6);  // wait
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h200,       6);
    vecs[13] = mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 1, 0, 32'h204,       7);
    vecs[14] = mk(0, 1, 1, 0, 0, 1, 32'h300,      1, 1, 0, 32'h100,       8);  // trap > jump
    vecs[15] = mk(1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h100,       8);
    vecs[16] = mk(1, 1, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h100,       8);  // trap in stall
    vecs[17] = mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 1, 0, 32'h104,       9);
    vecs[18] = mk(0, 1, 0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h100,       9);  // trap, waiting
    vecs[19] = mk(0, 0, 1, 0, 0, 1, 32'h42,       1, 1, mis_exp, mis_pc,  10); // misaligned
    vecs[20] = mk(1, 1, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h100,       10); // trap+stall
    vecs[21] = mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 1, 0, 32'h104,       11);
    vecs[22] = mk(0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 0, 32'hFFFF_FFFC, 12);
    vecs[23] = mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,         13); // wrap
    vecs[24] = mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 1, 0, 32'h4,         14);

    rst_n = 1'b0; stall = 1'b0; trap = 1'b0; imem_ready = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0; pc_target = 32'h0;
    model_pc = 32'h0;
    #1;
    chk("reset pc", pc, 32'h0);
    chk("reset instret", instret, 32'h0);
    chk("reset imem_req", {31'd0, imem_req}, 32'd0);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset fetch_fire", {31'd0, fetch_fire}, 32'd0);
    chk("reset misalign_err", {31'd0, misalign_err}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset asserted in the middle of an accept cycle.
    @(negedge clk);
    stall = 1'b0; trap = 1'b0; imem_ready = 1'b1;
    branch = 1'b0; zero = 1'b0; jump = 1'b0; pc_target = 32'h0;
    #1;
    chk("pre-reset fetch_fire", {31'd0, fetch_fire}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset pc", pc, 32'h0);
    chk("async reset imem_req", {31'd0, imem_req}, 32'd0);
    chk("async reset instret", instret, 32'h0);
    chk("async reset fetch_fire", {31'd0, fetch_fire}, 32'd0);
    @(posedge clk);
    #1;
    chk("held reset pc", pc, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_pc = 32'h0;
    run_vec(100, mk(0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0));
    run_vec(101, mk(0, 0, 1, 0, 0, 0, 32'h0, 1, 1, 0, 32'h4, 1));

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
